fetch_prefetch_unit: RTL and testbench

Parametrised instruction-fetch stage with a prefetch queue, for the next-generation pipelined core. It owns the PC and issues in-order requests to a variable-latency instruction memory, keeping up to MAX_OUT requests in flight. It buffers returned instructions with their PCs in a DEPTH-entry queue and hands them to ID through a valid/ready handshake. Branch/jump redirects flush the queue and discard stale in-flight responses. Halt freezes fetch.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/sync_fifo.sv | 46 ++++
 rtl/fetch_prefetch_unit.sv | 78 +++++++
 tb/tb_fetch_prefetch_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared core widths, reset PC and the fetch-queue entry type.
package cpu_pkg;
    localparam int CPU_PC_W = 16;
    localparam int CPU_INSTR_W = 16;
    localparam logic [CPU_PC_W-1:0] CPU_RESET_PC = '0;
    typedef struct packed {
        logic [CPU_PC_W-1:0]    pc;
        logic [CPU_INSTR_W-1:0] instr;
    } fetch_entry_t;
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with flush; head output reads zero while empty.
module sync_fifo import cpu_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [WIDTH-1:0]           o_rdata,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int AW = clog2_min1(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [CW-1:0] r_cnt;
    logic w_push, w_pop;
    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction
    assign w_push = i_push & !o_full;
    assign w_pop = i_pop & !o_empty;
    assign o_full = r_cnt == CW'(DEPTH);
    assign o_empty = r_cnt == '0;
    assign o_count = r_cnt;
    assign o_rdata = o_empty ? '0 : r_mem[r_rd];
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr <= '0;
            r_rd <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_wdata;
                r_wr <= inc(r_wr);
            end
            if (w_pop) r_rd <= inc(r_rd);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: PC owner issuing in-order imem requests into a prefetch queue,
// with redirect flush/stale-response dropping and sticky halt.
module fetch_prefetch_unit import cpu_pkg::*; #(
    parameter int               PC_W     = CPU_PC_W,
    parameter int               INSTR_W  = CPU_INSTR_W,
    parameter int               DEPTH    = 4,
    parameter int               MAX_OUT  = 2,
    parameter logic [PC_W-1:0]  RESET_PC = PC_W'(CPU_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [PC_W-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               halt,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [PC_W-1:0]    id_pc,
    output logic               busy
);
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int QW = $clog2(DEPTH + 1);
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;
    logic [PC_W-1:0] r_pc;
    logic [OW-1:0] r_out, r_drop;
    logic r_halted;
    logic w_fire, w_deq, w_rsp, w_keep;
    logic w_q_empty, w_q_full, w_inf_empty, w_inf_full;
    logic [QW-1:0] w_q_cnt;
    logic [OW-1:0] w_inf_cnt;
    logic [PC_W-1:0] w_inf_pc;
    logic [31:0] w_credit;
    entry_t w_head, w_entry;
    logic w_unused;
    // Credit counts only live requests: stale ones never land in the queue.
    assign w_credit = 32'(w_q_cnt) + 32'(r_out - r_drop);
    assign imem_req_valid = !rst & !r_halted & !redirect & (r_out < OW'(MAX_OUT)) & (w_credit < 32'(DEPTH));
    assign imem_req_addr = r_pc;
    assign w_fire = imem_req_valid & imem_req_ready;
    assign w_deq = id_valid & id_ready;
    assign w_rsp = imem_rsp_valid & (r_out != '0);
    assign w_keep = w_rsp & !redirect & (r_drop == '0);
    assign w_entry = '{pc: w_inf_pc, instr: imem_rsp_data};
    assign id_valid = !w_q_empty;
    assign id_pc = w_head.pc;
    assign id_instr = w_head.instr;
    assign busy = (r_out != '0) | !w_q_empty;
    assign w_unused = ^{w_q_full, w_inf_full, w_inf_empty, w_inf_cnt};
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
            r_out <= '0;
            r_drop <= '0;
            r_halted <= 1'b0;
        end else begin
            r_pc <= redirect ? redirect_pc : w_fire ? r_pc + PC_W'(INSTR_W / 8) : r_pc;
            r_out <= r_out + OW'(w_fire) - OW'(w_rsp);
            r_drop <= redirect ? r_out + OW'(w_fire) - OW'(w_rsp) : r_drop - OW'(w_rsp && r_drop != '0);
            r_halted <= r_halted | halt;
        end
    end
    sync_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_queue (
        .clk(clk), .rst(rst), .i_push(w_keep), .i_pop(w_deq), .i_flush(redirect),
        .i_wdata(w_entry), .o_rdata(w_head), .o_count(w_q_cnt), .o_full(w_q_full), .o_empty(w_q_empty)
    );
    sync_fifo #(.WIDTH(PC_W), .DEPTH(MAX_OUT)) u_inflight (
        .clk(clk), .rst(rst), .i_push(w_fire), .i_pop(w_keep), .i_flush(redirect),
        .i_wdata(r_pc), .o_rdata(w_inf_pc), .o_count(w_inf_cnt), .o_full(w_inf_full), .o_empty(w_inf_empty)
    );
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit: directed checks of fetch, backpressure, redirect, halt, wrap and reset
// against a fixed-latency in-order memory model.
module tb_fetch_prefetch_unit;
    logic clk = 1'b0, rst = 1'b1;
    logic imem_req_valid, imem_req_ready = 1'b1;
    logic [15:0] imem_req_addr;
    logic imem_rsp_valid = 1'b0;
    logic [15:0] imem_rsp_data = '0;
    logic redirect = 1'b0, halt = 1'b0, id_ready = 1'b1;
    logic [15:0] redirect_pc = '0;
    logic id_valid, busy;
    logic [15:0] id_instr, id_pc;
    int n_cmp = 0, n_err = 0, n_fire = 0, cyc = 0, lat = 1, n;
    int due_q[$];
    logic [15:0] adr_q[$], got_pc[$], got_in[$];

    fetch_prefetch_unit #(.PC_W(16), .INSTR_W(16), .DEPTH(4), .MAX_OUT(2), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt), .id_valid(id_valid),
        .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mk(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Samples handshakes before the edge, then plays the memory for the new cycle.
    task automatic step();
        logic f, r;
        logic [15:0] a;
        #1;
        f = imem_req_valid & imem_req_ready;
        a = imem_req_addr;
        r = rst;
        if (id_valid && id_ready) begin
            got_pc.push_back(id_pc);
            got_in.push_back(id_instr);
        end
        if (f) begin
            n_fire++;
            due_q.push_back(cyc + lat);
            adr_q.push_back(a);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (r) begin
            due_q.delete();
            adr_q.delete();
        end
        imem_rsp_valid = 1'b0;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data = mk(adr_q[0]);
            void'(due_q.pop_front());
            void'(adr_q.pop_front());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        got_pc.delete();
        got_in.delete();
        n_fire = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // reset values
        step();
        step();
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_id_valid", id_valid, 0);
        chk("rst_id_instr", id_instr, 0);
        chk("rst_id_pc", id_pc, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        #1;
        chk("first_req_valid", imem_req_valid, 1);
        chk("first_req_addr", imem_req_addr, 16'h0000);
        // free run, 1-cycle memory: id_pc 0,2,4.. from cycle 3
        step();
        step();
        for (int k = 0; k < 6; k++) begin
            chk("run_id_valid", id_valid, 1);
            chk("run_id_pc", id_pc, 2 * k);
            chk("run_id_instr", id_instr, mk(16'(2 * k)));
            chk("run_req_addr", imem_req_addr, 2 * (k + 2));
            step();
        end

        // backpressure: exactly DEPTH requests then stall
        id_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 8; k++) step();
        chk("bp_fires", n_fire, 4);
        chk("bp_req_valid", imem_req_valid, 0);
        chk("bp_id_valid", id_valid, 1);
        chk("bp_id_pc", id_pc, 0);
        chk("bp_busy", busy, 1);
        id_ready = 1'b1;
        for (int k = 0; k < 12; k++) step();
        chk("bp_count", got_pc.size(), 12);
        for (int i = 0; i < 12; i++) chk("bp_seq", got_pc[i], 2 * i);

        // 3-cycle memory, redirect with two requests in flight
        lat = 3;
        do_reset();
        step();
        step();
        chk("rd3_full_out", imem_req_valid, 0);
        redirect = 1'b1;
        redirect_pc = 16'h0100;
        step();
        redirect = 1'b0;
        #1;
        chk("rd3_no_req_cap", imem_req_valid, 0);
        chk("rd3_q_empty", id_valid, 0);
        step();
        chk("rd3_req_valid", imem_req_valid, 1);
        chk("rd3_req_addr", imem_req_addr, 16'h0100);
        n = 0;
        while (!id_valid && n < 20) begin
            step();
            n++;
        end
        chk("rd3_latency", n, 4);
        chk("rd3_id_pc", id_pc, 16'h0100);
        chk("rd3_id_instr", id_instr, mk(16'h0100));
        chk("rd3_no_old", got_pc.size(), 0);

        // redirect in the same cycle as a response
        lat = 1;
        do_reset();
        step();
        step();
        redirect = 1'b1;
        redirect_pc = 16'h0200;
        id_ready = 1'b0;
        step();
        redirect = 1'b0;
        id_ready = 1'b1;
        #1;
        chk("rdr_req_valid", imem_req_valid, 1);
        chk("rdr_req_addr", imem_req_addr, 16'h0200);
        chk("rdr_q_empty", id_valid, 0);
        got_pc.delete();
        for (int k = 0; k < 6; k++) step();
        chk("rdr_count", got_pc.size(), 4);
        chk("rdr_pc0", got_pc[0], 16'h0200);
        chk("rdr_pc1", got_pc[1], 16'h0202);
        chk("rdr_pc2", got_pc[2], 16'h0204);

        // halt with two outstanding
        lat = 3;
        do_reset();
        step();
        step();
        halt = 1'b1;
        step();
        halt = 1'b0;
        n_fire = 0;
        got_pc.delete();
        got_in.delete();
        for (int k = 0; k < 8; k++) step();
        chk("halt_fires", n_fire, 0);
        chk("halt_count", got_pc.size(), 2);
        chk("halt_pc0", got_pc[0], 16'h0000);
        chk("halt_pc1", got_pc[1], 16'h0002);
        chk("halt_in1", got_in[1], mk(16'h0002));
        chk("halt_busy", busy, 0);
        redirect = 1'b1;
        redirect_pc = 16'h0300;
        step();
        redirect = 1'b0;
        #1;
        chk("halt_rd_req", imem_req_valid, 0);
        for (int k = 0; k < 3; k++) step();
        chk("halt_rd_fires", n_fire, 0);
        chk("halt_rd_busy", busy, 0);

        // PC wrap, then mid-stream reset
        lat = 1;
        do_reset();
        redirect = 1'b1;
        redirect_pc = 16'hFFFE;
        step();
        redirect = 1'b0;
        #1;
        chk("wrap_req_addr", imem_req_addr, 16'hFFFE);
        for (int k = 0; k < 5; k++) step();
        chk("wrap_count", got_pc.size(), 3);
        chk("wrap_pc0", got_pc[0], 16'hFFFE);
        chk("wrap_in0", got_in[0], mk(16'hFFFE));
        chk("wrap_pc1", got_pc[1], 16'h0000);
        chk("wrap_pc2", got_pc[2], 16'h0002);
        rst = 1'b1;
        step();
        chk("mrst_req_valid", imem_req_valid, 0);
        chk("mrst_id_valid", id_valid, 0);
        chk("mrst_id_pc", id_pc, 0);
        chk("mrst_id_instr", id_instr, 0);
        chk("mrst_busy", busy, 0);
        rst = 1'b0;
        #1;
        chk("mrst_restart_valid", imem_req_valid, 1);
        chk("mrst_restart_addr", imem_req_addr, 16'h0000);
        step();
        step();
        chk("mrst_id_valid2", id_valid, 1);
        chk("mrst_id_pc2", id_pc, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
